matrix_entry_loader: RTL and testbench

MATRIX_ENTRY_LOADER -- requirements
Module: matrix_entry_loader

---
 rtl/matrix_entry_loader_if.sv | 33 +++
 rtl/matrix_entry_loader.sv | 120 ++++++++++++
 tb/tb_matrix_entry_loader.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_entry_loader_if.sv
// Handshake/bus bundle between a host/solver and the matrix entry loader.
// Signal suffixes are from the loader's point of view: _i into the loader, _o out of it.
interface matrix_entry_loader_if #(
   parameter int N = 8,
   parameter int W = 4
);
   logic               valid_i;
   logic [W-1:0]       data_i;
   logic               back_i;
   logic               clear_i;
   logic               go_i;
   logic               done_i;
   logic [N*N*W-1:0]   input_arr_flat_o;
   logic               start_o;
   logic               ack_o;
   logic [6:0]         index_o;
   logic               q_fill_o;
   logic               q_full_o;
   logic               q_run_o;
   logic               q_ack_o;

   modport master (
      output valid_i, data_i, back_i, clear_i, go_i, done_i,
      input  input_arr_flat_o, start_o, ack_o, index_o,
             q_fill_o, q_full_o, q_run_o, q_ack_o
   );

   modport slave (
      input  valid_i, data_i, back_i, clear_i, go_i, done_i,
      output input_arr_flat_o, start_o, ack_o, index_o,
             q_fill_o, q_full_o, q_run_o, q_ack_o
   );
endinterface

// File: rtl/matrix_entry_loader.sv
// Collects N*N entries one strobe at a time (with undo/clear), then hands the
// assembled matrix to a determinant solver through a registered Start/Ack handshake.
module matrix_entry_loader #(
   parameter int N = 8,
   parameter int W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   matrix_entry_loader_if.slave  bus
);
   localparam int         ENTRIES  = N * N;
   localparam logic [6:0] IDX_FULL = 7'(ENTRIES);
   localparam logic [6:0] IDX_LAST = 7'(ENTRIES - 1);

   typedef enum logic [3:0] {
      S_FILL = 4'b0001,
      S_FULL = 4'b0010,
      S_RUN  = 4'b0100,
      S_ACK  = 4'b1000
   } state_e;

   state_e           state_q, state_d;
   logic [6:0]       index_q, index_d;
   logic             start_q, ack_q;
   logic             wr_en;
   logic [6:0]       wr_idx;
   logic [W-1:0]     wr_val;
   logic             clr_all;
   logic [ENTRIES*W-1:0] flat;

   // The FSM decides a single entry update per cycle (write or zero) plus an
   // optional whole-matrix clear; the entry registers below just apply it.
   always_comb begin
      state_d = state_q;
      index_d = index_q;
      wr_en   = 1'b0;
      wr_idx  = index_q;
      wr_val  = bus.data_i;
      clr_all = 1'b0;
      case (state_q)
         S_FILL: begin
            if (bus.clear_i) begin
               clr_all = 1'b1;
               index_d = '0;
            end else if (bus.valid_i) begin
               wr_en   = 1'b1;
               index_d = index_q + 7'd1;
               if (index_q + 7'd1 == IDX_FULL)
                  state_d = S_FULL;
            end else if (bus.back_i && index_q != 7'd0) begin
               wr_en   = 1'b1;
               wr_idx  = index_q - 7'd1;
               wr_val  = '0;
               index_d = index_q - 7'd1;
            end
         end
         S_FULL: begin
            if (bus.clear_i) begin
               clr_all = 1'b1;
               index_d = '0;
               state_d = S_FILL;
            end else if (bus.back_i) begin
               wr_en   = 1'b1;
               wr_idx  = IDX_LAST;
               wr_val  = '0;
               index_d = IDX_LAST;
               state_d = S_FILL;
            end else if (bus.go_i) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (bus.done_i)
               state_d = S_ACK;
         end
         S_ACK:   state_d = S_FULL;
         default: state_d = S_FILL;
      endcase
   end

   // Start/Ack are decoded from the next state so they rise together with the
   // state change and carry no combinational path from the inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FILL;
         index_q <= '0;
         start_q <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         start_q <= (state_d == S_RUN);
         ack_q   <= (state_d == S_ACK);
      end
   end

   for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic [W-1:0] entry_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            entry_q <= '0;
         else if (clr_all)
            entry_q <= '0;
         else if (wr_en && wr_idx == 7'(gi))
            entry_q <= wr_val;
      end

      assign flat[gi*W +: W] = entry_q;
   end

   assign bus.input_arr_flat_o = flat;
   assign bus.start_o          = start_q;
   assign bus.ack_o            = ack_q;
   assign bus.index_o          = index_q;
   assign bus.q_fill_o         = state_q[0];
   assign bus.q_full_o         = state_q[1];
   assign bus.q_run_o          = state_q[2];
   assign bus.q_ack_o          = state_q[3];
endmodule

// File: tb/tb_matrix_entry_loader.sv
// Directed bench for matrix_entry_loader: a per-cycle reference model of the
// loader's rules plus hand-computed literal checks and a mock determinant solver.
module tb_matrix_entry_loader;
   localparam int M_FILL = 0, M_FULL = 1, M_RUN = 2, M_ACK = 3;
   localparam logic [255:0] RAMP = {4{64'hFEDCBA9876543210}};

   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;
   bit   cmp_en = 1'b0;

   int   m_mat [64];
   int   m_idx;
   int   m_state;

   matrix_entry_loader_if #(.N(8), .W(4)) bus ();

   matrix_entry_loader #(.N(8), .W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] model_flat();
      logic [255:0] r = '0;
      for (int k = 0; k < 64; k++) r[k*4 +: 4] = m_mat[k][3:0];
      return r;
   endfunction

   // Reference behaviour: what the loader must hold after each edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 64; k++) m_mat[k] = 0;
         m_idx = 0;
         m_state = M_FILL;
      end else begin
         case (m_state)
            M_FILL: begin
               if (bus.clear_i) begin
                  for (int k = 0; k < 64; k++) m_mat[k] = 0;
                  m_idx = 0;
               end else if (bus.valid_i) begin
                  m_mat[m_idx] = int'(bus.data_i);
                  m_idx++;
                  if (m_idx == 64) m_state = M_FULL;
               end else if (bus.back_i && m_idx > 0) begin
                  m_idx--;
                  m_mat[m_idx] = 0;
               end
            end
            M_FULL: begin
               if (bus.clear_i) begin
                  for (int k = 0; k < 64; k++) m_mat[k] = 0;
                  m_idx = 0;
                  m_state = M_FILL;
               end else if (bus.back_i) begin
                  m_idx = 63;
                  m_mat[63] = 0;
                  m_state = M_FILL;
               end else if (bus.go_i) begin
                  m_state = M_RUN;
               end
            end
            M_RUN: if (bus.done_i) m_state = M_ACK;
            default: m_state = M_FULL;
         endcase
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("flat",   bus.input_arr_flat_o, model_flat());
         check("index",  256'(bus.index_o),    256'(m_idx));
         check("start",  256'(bus.start_o),    256'(m_state == M_RUN));
         check("ack",    256'(bus.ack_o),      256'(m_state == M_ACK));
         check("q_fill", 256'(bus.q_fill_o),   256'(m_state == M_FILL));
         check("q_full", 256'(bus.q_full_o),   256'(m_state == M_FULL));
         check("q_run",  256'(bus.q_run_o),    256'(m_state == M_RUN));
         check("q_ack",  256'(bus.q_ack_o),    256'(m_state == M_ACK));
      end
   end

   task automatic drive(input logic v, input logic [3:0] d, input logic b,
                        input logic c, input logic g, input logic dn);
      bus.valid_i = v;
      bus.data_i  = d;
      bus.back_i  = b;
      bus.clear_i = c;
      bus.go_i    = g;
      bus.done_i  = dn;
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
      bus.data_i  = '0;
      bus.back_i  = 1'b0;
      bus.clear_i = 1'b0;
      bus.go_i    = 1'b0;
      bus.done_i  = 1'b0;
   endtask

   // Mock solver: determinant of the presented 8x8 matrix, Gaussian elimination.
   function automatic int det8(input logic [255:0] f);
      real a [8][8];
      real d = 1.0;
      real t;
      int  p;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            a[i][j] = real'(int'(f[(i*8+j)*4 +: 4]));
      for (int c = 0; c < 8; c++) begin
         p = c;
         for (int r = c + 1; r < 8; r++)
            if ((a[r][c] < 0 ? -a[r][c] : a[r][c]) > (a[p][c] < 0 ? -a[p][c] : a[p][c])) p = r;
         if ((a[p][c] < 0 ? -a[p][c] : a[p][c]) < 1e-9) return 0;
         if (p != c) begin
            for (int j = 0; j < 8; j++) begin
               t = a[c][j]; a[c][j] = a[p][j]; a[p][j] = t;
            end
            d = -d;
         end
         d = d * a[c][c];
         for (int r = c + 1; r < 8; r++) begin
            t = a[r][c] / a[c][c];
            for (int j = c; j < 8; j++) a[r][j] = a[r][j] - t * a[c][j];
         end
      end
      return $rtoi(d >= 0.0 ? d + 0.5 : d - 0.5);
   endfunction

   initial begin
      rst = 1'b1;
      bus.valid_i = 1'b0; bus.data_i = '0; bus.back_i = 1'b0;
      bus.clear_i = 1'b0; bus.go_i = 1'b0; bus.done_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_flat",  bus.input_arr_flat_o, 256'd0);
      check("rst_index", 256'(bus.index_o), 256'd0);
      check("rst_start", 256'(bus.start_o), 256'd0);
      check("rst_fill",  256'(bus.q_fill_o), 256'd1);
      rst = 1'b0;
      cmp_en = 1'b1;

      // Ramp fill: entry k = k mod 16, then an ignored 65th Valid.
      for (int k = 0; k < 64; k++) drive(1'b1, 4'(k % 16), 1'b0, 1'b0, 1'b0, 1'b0);
      check("ramp_flat",  bus.input_arr_flat_o, RAMP);
      check("ramp_index", 256'(bus.index_o), 256'd64);
      check("ramp_full",  256'(bus.q_full_o), 256'd1);
      drive(1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);
      check("ramp_65th",  bus.input_arr_flat_o, RAMP);

      // Run with a long solver delay, then Done.
      drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("go_start", 256'(bus.start_o), 256'd1);
      check("ramp_det", 256'(det8(bus.input_arr_flat_o)), 256'd0);
      repeat (100) drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("run_frozen", bus.input_arr_flat_o, RAMP);
      drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("done_ack",   256'(bus.ack_o), 256'd1);
      check("done_start", 256'(bus.start_o), 256'd0);
      drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("ack_gone", 256'(bus.ack_o), 256'd0);
      check("back_full", 256'(bus.q_full_o), 256'd1);

      // Clear beats Go in FULL.
      drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
      check("clrgo_flat",  bus.input_arr_flat_o, 256'd0);
      check("clrgo_index", 256'(bus.index_o), 256'd0);
      check("clrgo_fill",  256'(bus.q_fill_o), 256'd1);
      check("clrgo_start", 256'(bus.start_o), 256'd0);

      // Undo: 5,6,7, Back, 9 -> 5,6,9.
      drive(1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0);
      check("undo_flat",  bus.input_arr_flat_o, 256'h965);
      check("undo_index", 256'(bus.index_o), 256'd3);
      drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("back0_flat",  bus.input_arr_flat_o, 256'd0);
      check("back0_index", 256'(bus.index_o), 256'd0);

      // Valid and Back together: write only.
      drive(1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0);
      check("vb_flat",  bus.input_arr_flat_o, 256'hA);
      check("vb_index", 256'(bus.index_o), 256'd1);

      // Back from FULL reopens the last entry.
      drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 64; k++) drive(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      check("fback_flat",  bus.input_arr_flat_o, {4'h0, {63{4'h3}}});
      check("fback_index", 256'(bus.index_o), 256'd63);
      check("fback_fill",  256'(bus.q_fill_o), 256'd1);
      drive(1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
      check("refill_flat", bus.input_arr_flat_o, {4'h5, {63{4'h3}}});

      // Inputs ignored in RUN, then an asynchronous reset mid-run.
      drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (3) drive(1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
      check("run_ignore", bus.input_arr_flat_o, {4'h5, {63{4'h3}}});
      check("prerst_start", 256'(bus.start_o), 256'd1);
      rst = 1'b1;
      #1;
      check("arst_start", 256'(bus.start_o), 256'd0);
      check("arst_flat",  bus.input_arr_flat_o, 256'd0);
      check("arst_fill",  256'(bus.q_fill_o), 256'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Identity matrix through the solver handshake.
      drive(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("first_entry", bus.input_arr_flat_o, 256'h1);
      for (int k = 1; k < 64; k++) drive(1'b1, (k % 9 == 0) ? 4'h1 : 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("id_start", 256'(bus.start_o), 256'd1);
      check("id_det", 256'(det8(bus.input_arr_flat_o)), 256'd1);
      repeat (3) drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("id_ack", 256'(bus.ack_o), 256'd1);
      drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("id_full", 256'(bus.q_full_o), 256'd1);
      check("id_index", 256'(bus.index_o), 256'd64);

      @(negedge clk);
      cmp_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
